nv_nvdla_cdma_pfifo: RTL

Parametrised synchronous FIFO for CDMA weight/data side paths. It replaces fixed-geometry generated FIFOs with one block that has configurable width, depth and a runtime write limit. It also adds a live occupancy count, a peak-occupancy watermark and a synchronous flush. It sits between a CDMA request producer and its consumer using valid/ready handshakes on both sides.

---
 rtl/nv_nvdla_cdma_pfifo.sv | 80 ++++++++
 1 files changed

// File: rtl/nv_nvdla_cdma_pfifo.sv
// Parametrised valid/ready FIFO for CDMA side paths, with a runtime write limit and occupancy/peak tracking.
// Optional synchronous flush is compiled in with NV_NVDLA_PFIFO_FLUSH_EN.
module nv_nvdla_cdma_pfifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 128,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_req,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  input  logic [AW:0]      wr_limit,
  input  logic             flush,
  output logic [AW:0]      count,
  output logic [AW:0]      count_max
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_adr;
  logic [AW-1:0]    rd_adr;
  logic [AW:0]      count_next;
  logic [AW:0]      eff_limit;
  logic             flush_act;
  logic             push;
  logic             pop;

`ifdef NV_NVDLA_PFIFO_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  // A zero or out-of-range limit means the full geometry is usable.
  assign eff_limit = ((wr_limit == '0) || (wr_limit > DEPTH_W)) ? DEPTH_W : wr_limit;

  assign wr_ready = !reset && !flush_act && (count < eff_limit);
  assign rd_req   = !flush_act && (count != '0);
  assign rd_data  = rd_req ? mem[rd_adr] : '0;

  assign push = wr_req && wr_ready;
  assign pop  = rd_req && rd_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Pointer, occupancy and watermark state.
  always_ff @(posedge clk) begin
    if (reset || flush_act) begin
      wr_adr    <= '0;
      rd_adr    <= '0;
      count     <= '0;
      count_max <= '0;
    end else begin
      if (push) wr_adr <= wr_adr + AW'(1);
      if (pop)  rd_adr <= rd_adr + AW'(1);
      count <= count_next;
      if (count_next > count_max) count_max <= count_next;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_adr] <= wr_data;
  end

endmodule
